// File: rtl/video_pkg.sv
// Shared video timing defaults, unpacker state encoding and pixel field layout.
package video_pkg;

    localparam int H_ACTIVE         = 1920;
    localparam int V_ACTIVE         = 1080;
    localparam int PIXELS_PER_FRAME = H_ACTIVE * V_ACTIVE;
    localparam int FRAME_CNT_W      = 21;

    // Each 32-bit pixel is {unused, R, G, B}
    localparam int PIXEL_W = 32;
    localparam int R_LSB   = 16;
    localparam int G_LSB   = 8;
    localparam int B_LSB   = 0;
    localparam int RGB_W   = 24;

    typedef enum logic [1:0] {
        WAIT_FILL = 2'd0,
        WAIT_SOF  = 2'd1,
        STREAM    = 2'd2
    } unpack_state_e;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous level signal.
module bit_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pixel_unpacker.sv
// Reads 64-bit words from the pixel FIFO into a 2-word prefetch buffer and
// emits one 24-bit RGB pixel per display-enable cycle, tracking starvation and frame size.
module pixel_unpacker
    import video_pkg::*;
#(
    parameter int SDRAM_DATA_WIDTH = 64,
    parameter int H_ACTIVE         = video_pkg::H_ACTIVE,
    parameter int V_ACTIVE         = video_pkg::V_ACTIVE
) (
    input  logic                        pixel_clk,
    input  logic                        rst_n,
    input  logic                        first_fill_i,
    input  logic                        sof_i,
    input  logic                        de_i,
    output logic                        fifo_rdreq_o,
    input  logic [SDRAM_DATA_WIDTH-1:0] fifo_q_i,
    input  logic                        fifo_rdempty_i,
    output logic [23:0]                 rgb_o,
    output logic                        de_o,
    output logic [15:0]                 underflow_cnt_o,
    output logic                        frame_err_o
);

    localparam logic [FRAME_CNT_W-1:0] FRAME_PIXELS = FRAME_CNT_W'(H_ACTIVE * V_ACTIVE);

    logic fill_s;

    bit_sync u_fill_sync (
        .clk   (pixel_clk),
        .rst_n (rst_n),
        .d     (first_fill_i),
        .q     (fill_s)
    );

    unpack_state_e                state_q, state_d;
    logic [1:0][2*RGB_W-1:0]      buf_q;
    logic [1:0]                   occ_q;
    logic                         half_q;
    logic                         inflight_q;
    logic [FRAME_CNT_W-1:0]       frame_cnt_q;

    // Only the RGB bytes of each half are kept; the top byte of each pixel is discarded at capture
    logic [2*RGB_W-1:0] fifo_rgb;
    logic               unused_bits;
    assign fifo_rgb = {fifo_q_i[PIXEL_W+R_LSB +: 8], fifo_q_i[PIXEL_W+G_LSB +: 8], fifo_q_i[PIXEL_W+B_LSB +: 8],
                       fifo_q_i[R_LSB +: 8],         fifo_q_i[G_LSB +: 8],         fifo_q_i[B_LSB +: 8]};
    assign unused_bits = ^{fifo_q_i[PIXEL_W+RGB_W +: 8], fifo_q_i[RGB_W +: 8]};

    logic              sof_hit, active, consume, starve, pop;
    logic [1:0]        pending;
    logic [RGB_W-1:0]  head_rgb;

    assign sof_hit  = sof_i & de_i;
    assign active   = de_i & ((state_q == STREAM) | ((state_q == WAIT_SOF) & sof_i));
    assign consume  = active & (occ_q != 2'd0);
    assign starve   = active & (occ_q == 2'd0);
    assign pop      = consume & half_q;
    assign head_rgb = half_q ? buf_q[0][2*RGB_W-1:RGB_W] : buf_q[0][RGB_W-1:0];

    // Conservative room check: a word popped this cycle is still counted as occupied
    assign pending      = occ_q + {1'b0, inflight_q} + {1'b0, pop};
    assign fifo_rdreq_o = (state_q != WAIT_FILL) & ~fifo_rdempty_i & (pending < 2'd2);

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) state_q <= WAIT_FILL;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_FILL: if (fill_s)  state_d = WAIT_SOF;
            WAIT_SOF:  if (sof_hit) state_d = STREAM;
            STREAM:    state_d = STREAM;
            default:   state_d = WAIT_FILL;
        endcase
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q           <= '0;
            occ_q           <= '0;
            half_q          <= 1'b0;
            inflight_q      <= 1'b0;
            rgb_o           <= '0;
            de_o            <= 1'b0;
            underflow_cnt_o <= '0;
            frame_err_o     <= 1'b0;
            frame_cnt_q     <= '0;
        end else begin
            inflight_q <= fifo_rdreq_o;

            unique case ({inflight_q, pop})
                2'b10: begin
                    if (occ_q == 2'd0) buf_q[0] <= fifo_rgb;
                    else               buf_q[1] <= fifo_rgb;
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    buf_q[0] <= buf_q[1];
                    occ_q    <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        buf_q[0] <= fifo_rgb;
                    end else begin
                        buf_q[0] <= buf_q[1];
                        buf_q[1] <= fifo_rgb;
                    end
                end
                default: ;
            endcase

            if (consume) half_q <= ~half_q;

            de_o  <= de_i;
            rgb_o <= consume ? head_rgb : '0;

            if (starve && (underflow_cnt_o != '1))
                underflow_cnt_o <= underflow_cnt_o + 16'd1;

            if ((state_q == WAIT_SOF) && sof_hit) begin
                frame_cnt_q <= FRAME_CNT_W'(1);
            end else if ((state_q == STREAM) && de_i) begin
                if (sof_i) begin
                    if (frame_cnt_q != FRAME_PIXELS) frame_err_o <= 1'b1;
                    frame_cnt_q <= FRAME_CNT_W'(1);
                end else begin
                    frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/pixel_unpacker.md
PIXEL_UNPACKER -- requirements
Module: pixel_unpacker

Interface
REQ-001 SHALL have parameter SDRAM_DATA_WIDTH, default 64, FIFO word width (two 32-bit pixels per word).
REQ-002 SHALL have parameters H_ACTIVE (default 1920) and V_ACTIVE (default 1080), giving active pixels per line and lines per frame.
REQ-003 SHALL have port pixel_clk, input, 1: single clock; all logic is in this domain.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port first_fill_i, input, 1: "FIFO filled" flag from the sdram_clk domain, asynchronous to this block.
REQ-006 SHALL have port sof_i, input, 1: start of frame from the timing generator, valid only with de_i=1 on the first active pixel.
REQ-007 SHALL have port de_i, input, 1: display requests one pixel this cycle.
REQ-008 SHALL have port fifo_rdreq_o, output, 1: read request to the standard-mode pixel FIFO.
REQ-009 SHALL have port fifo_q_i, input, SDRAM_DATA_WIDTH: FIFO data, valid exactly one cycle after an accepted rdreq.
REQ-010 SHALL have port fifo_rdempty_i, input, 1: FIFO empty, read side.
REQ-011 SHALL have port rgb_o, output, 24: pixel {R,G,B}.
REQ-012 SHALL have port de_o, output, 1: de_i delayed by 1 cycle.
REQ-013 SHALL have port underflow_cnt_o, output, 16: saturating count of starved pixels.
REQ-014 SHALL have port frame_err_o, output, 1: sticky flag for a frame pixel-count mismatch.

Function
REQ-015 SHALL pass first_fill_i through a 2-flop synchronizer before use; the synchronized value is fill_s.
REQ-016 SHALL implement states WAIT_FILL, WAIT_SOF and STREAM.
- WAIT_FILL -> WAIT_SOF when fill_s=1.
- WAIT_SOF -> STREAM on sof_i&de_i.
- There are no other transitions except reset.
REQ-017 SHALL keep fifo_rdreq_o=0 in WAIT_FILL.
REQ-018 SHALL prefetch in WAIT_SOF and STREAM into a 2-entry word buffer.
- Assert fifo_rdreq_o only when ~fifo_rdempty_i and (buffered words + in-flight reads + words popped this cycle) < 2.
- Buffer occupancy SHALL never exceed 2.
REQ-019 SHALL capture fifo_q_i into the buffer on the cycle after each fifo_rdreq_o=1.
REQ-020 SHALL unpack pixels within a word in this order:
- pixel 0 = bits [31:0], pixel 1 = bits [63:32].
- Each pixel is {unused[31:24], R[23:16], G[15:8], B[7:0]}.
- A half-select bit alternates on each consumed pixel; the head word pops when pixel 1 is consumed.
REQ-021 SHALL, in STREAM (including the sof_i entry cycle), consume one pixel per de_i=1 cycle when the buffer is non-empty; rgb_o shows that pixel on the next cycle with de_o=1.
REQ-022 SHALL treat de_i=1 with an empty buffer in STREAM as a starved pixel:
- rgb_o=24'h000000 on the next cycle.
- No half/pop advance.
- underflow_cnt_o increments, saturating at 16'hFFFF.
REQ-023 SHALL keep rgb_o=0 and consume nothing in WAIT_FILL and WAIT_SOF; de_o still follows de_i.
REQ-024 SHALL count consumed-or-starved pixels in a 21-bit frame counter.
- On sof_i&de_i in STREAM: if count != H_ACTIVE*V_ACTIVE, set frame_err_o; then load the counter with 1.
- On entry to STREAM, load the counter with 1 with no check.
REQ-025 SHALL ignore sof_i when de_i=0.
REQ-026 SHALL give a simultaneous buffer write and pop a net occupancy change of 0.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously clear the following:
- state=WAIT_FILL, buffer empty, half-select=0, in-flight=0.
- synchronizer=0, fifo_rdreq_o=0, rgb_o=0, de_o=0, underflow_cnt_o=0, frame_err_o=0, frame counter=0.
REQ-028 SHALL, on reset assertion mid-STREAM, discard buffered and in-flight data; a read returning after deassertion SHALL be ignored.

Structure
REQ-029 SHALL take H_ACTIVE, V_ACTIVE, PIXELS_PER_FRAME, the state enum and the pixel field positions from a shared package video_pkg.
REQ-030 SHALL instantiate one sub-module, bit_sync (a 2-flop synchronizer with async active-low reset), for first_fill_i.

Verification
REQ-031 SHALL check: reset, then first_fill_i=1 -> fifo_rdreq_o stays 0 for ≥2 cycles, then exactly 2 reads issue, then none.
REQ-032 SHALL check: FIFO words 64'h00AABBCC_00112233, 64'h00445566_00778899, then sof_i&de_i followed by 3 de_i cycles -> rgb_o = 112233, AABBCC, 778899, 445566 on successive cycles, each with de_o=1.
REQ-033 SHALL check: fifo_rdempty_i=1 in STREAM with 5 de_i cycles after the buffer drains -> rgb_o=0 and underflow_cnt_o increases by 5.
REQ-034 SHALL check: a second sof_i after 100 pixels with H_ACTIVE=8 and V_ACTIVE=4 -> frame_err_o=1; sof_i after exactly 32 pixels -> frame_err_o stays 0.
REQ-035 SHALL check: rst_n pulsed low mid-STREAM with a read in flight -> all outputs 0 immediately, state WAIT_FILL, and the stale q is not captured.
